// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage. Issues one read at a time to instruction memory.
// Returned instructions go into a single output slot that feeds the IF/ID
// register. A one-entry skid buffer absorbs a read that completes while
// decode is stalled. Branch/jump redirects flush the slot and the skid. A
// read already in flight when a redirect arrives is drained and its data
// is dropped.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   stall           : decode cannot take a new instruction this cycle
//   redirect        : taken branch/jump, flush and refetch at redirect_pc
//   redirect_pc     : redirect target address
//   imem_req        : read request to instruction memory
//   imem_addr       : read address, stable until the ack cycle
//   imem_ack        : one-cycle pulse, imem_rdata valid
//   imem_rdata      : read data
//   IF_PC           : fetched address + PC_STEP
//   IF_Instruction  : fetched instruction
//   IF_valid        : IF_PC/IF_Instruction hold an unconsumed instruction
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int                     ADDRESS_LEN     = 32,
    parameter int                     INSTRUCTION_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0,
    parameter int                     PC_STEP         = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [ADDRESS_LEN-1:0]     redirect_pc,
    output logic                       imem_req,
    output logic [ADDRESS_LEN-1:0]     imem_addr,
    input  logic                       imem_ack,
    input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
    output logic [ADDRESS_LEN-1:0]     IF_PC,
    output logic [INSTRUCTION_LEN-1:0] IF_Instruction,
    output logic                       IF_valid
);

    localparam logic [ADDRESS_LEN-1:0] STEP = ADDRESS_LEN'(PC_STEP);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request active
        S_HOLD  = 2'd1,   // skid full, no request
        S_DRAIN = 2'd2    // waiting out a read made stale by a redirect
    } state_t;

    state_t                     state_reg;
    logic [ADDRESS_LEN-1:0]     pc_reg;
    logic [ADDRESS_LEN-1:0]     drain_addr_reg;
    logic [ADDRESS_LEN-1:0]     skid_pc_reg;
    logic [INSTRUCTION_LEN-1:0] skid_instr_reg;

    logic [ADDRESS_LEN-1:0]     pc_next;
    logic                       slot_free;

    // Addition wraps naturally at the register width.
    assign pc_next   = pc_reg + STEP;
    assign slot_free = !IF_valid || !stall;

    // While draining, pc_reg already holds the redirect target. The stale
    // address is kept separately so the outstanding request stays stable.
    assign imem_req  = !rst && (state_reg != S_HOLD);
    assign imem_addr = (state_reg == S_DRAIN) ? drain_addr_reg : pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_FETCH;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= '0;
            skid_pc_reg    <= '0;
            skid_instr_reg <= '0;
            IF_PC          <= '0;
            IF_Instruction <= '0;
            IF_valid       <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (redirect) begin
                        pc_reg   <= redirect_pc;
                        IF_valid <= 1'b0;
                        // Without an ack the read is still outstanding and
                        // must complete before the next one is issued.
                        if (!imem_ack) begin
                            drain_addr_reg <= pc_reg;
                            state_reg      <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc_reg <= pc_next;
                        if (slot_free) begin
                            IF_Instruction <= imem_rdata;
                            IF_PC          <= pc_next;
                            IF_valid       <= 1'b1;
                        end else begin
                            skid_instr_reg <= imem_rdata;
                            skid_pc_reg    <= pc_next;
                            state_reg      <= S_HOLD;
                        end
                    end else if (IF_valid && !stall) begin
                        IF_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc_reg    <= redirect_pc;
                        IF_valid  <= 1'b0;
                        state_reg <= S_FETCH;
                    end else if (!stall) begin
                        IF_Instruction <= skid_instr_reg;
                        IF_PC          <= skid_pc_reg;
                        IF_valid       <= 1'b1;
                        state_reg      <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (redirect) begin
                        pc_reg <= redirect_pc;
                    end
                    // The stale read ends on its ack. A redirect in the
                    // same cycle must not leave the FSM waiting for an ack
                    // that will never arrive.
                    if (imem_ack) begin
                        state_reg <= S_FETCH;
                    end
                end
                default: begin
                    state_reg <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit. The memory model has a programmable
// latency and returns rdata = addr + 0x100. Expected instructions are queued
// when stimulus is set up. They are popped whenever decode takes the output
// slot (IF_valid=1, stall=0, no redirect). A second instance checks the
// address wrap from RESET_PC = all ones.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_PC, IF_Instruction;
    logic        IF_valid;

    logic        rst2;
    logic        w_req, w_ack, w_valid;
    logic [31:0] w_addr, w_rdata, w_pc, w_instr;

    int          lat;
    int          mem_cnt;
    logic        force_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    // Memory model: ack on the lat-th cycle of a request (lat=1: zero wait).
    assign imem_ack   = (imem_req && (mem_cnt + 1 >= lat)) || force_ack;
    assign imem_rdata = imem_addr + 32'h100;

    always @(posedge clk or posedge rst) begin
        if (rst)                       mem_cnt <= 0;
        else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 1;
        else                           mem_cnt <= 0;
    end

    assign w_ack   = w_req;
    assign w_rdata = w_addr + 32'h100;

    if_fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .IF_PC          (IF_PC),
        .IF_Instruction (IF_Instruction),
        .IF_valid       (IF_valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) u_dut_wrap (
        .clk            (clk),
        .rst            (rst2),
        .stall          (1'b0),
        .redirect       (1'b0),
        .redirect_pc    (32'h0),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_ack),
        .imem_rdata     (w_rdata),
        .IF_PC          (w_pc),
        .IF_Instruction (w_instr),
        .IF_valid       (w_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr);
        exp_t e;
        e.pc    = addr + 32'd1;
        e.instr = addr + 32'h100;
        exp_q.push_back(e);
    endtask

    // Score the output slot if decode takes it this cycle, then advance
    // one clock and settle.
    task automatic step();
        exp_t e;
        if (IF_valid && !stall && !redirect) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL sb_extra observed IF_PC=0x%0h expected no output", IF_PC);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", IF_PC, e.pc);
                chk("sb_instr", IF_Instruction, e.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!IF_valid && n < max_cycles) begin
            step();
            n++;
        end
        chk("wait_valid_timeout", 32'(IF_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; lat = 1; force_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_valid", 32'(IF_valid), 32'd0);
        chk("rst_pc", IF_PC, 32'd0);
        chk("rst_instr", IF_Instruction, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        // An ack arriving during reset has no effect.
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("rst_ack_ignored", 32'(IF_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);

        // Zero-wait streaming, then a 3-cycle stall after addr 4 is output.
        for (int a = 0; a < 7; a++) push_exp(32'(a));
        repeat (5) step();
        chk("stream_pc", IF_PC, 32'd5);
        chk("stream_instr", IF_Instruction, 32'h104);
        stall = 1'b1;
        step();
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_valid", 32'(IF_valid), 32'd1);
        step();
        step();
        chk("hold_pc", IF_PC, 32'd5);
        chk("hold_instr", IF_Instruction, 32'h104);
        chk("hold_req2", 32'(imem_req), 32'd0);
        stall = 1'b0;
        step();
        chk("skid_pc", IF_PC, 32'd6);
        chk("skid_instr", IF_Instruction, 32'h105);
        step();
        chk("after_skid_pc", IF_PC, 32'd7);

        // Redirect while a slow read of addr 7 is pending, twice in DRAIN.
        lat = 4;
        step();
        chk("b_bubble", 32'(IF_valid), 32'd0);
        chk("b_addr", imem_addr, 32'd7);
        chk("b_sb_empty", 32'(exp_q.size()), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h30;
        step();
        chk("drain_addr", imem_addr, 32'd7);
        chk("drain_valid", 32'(IF_valid), 32'd0);
        chk("drain_req", 32'(imem_req), 32'd1);
        redirect_pc = 32'h40;
        step();
        chk("drain2_addr", imem_addr, 32'd7);
        redirect = 1'b0;
        push_exp(32'h40);
        push_exp(32'h41);
        step();
        chk("refetch_addr", imem_addr, 32'h40);
        chk("refetch_valid", 32'(IF_valid), 32'd0);
        wait_valid(20);
        chk("redir_pc", IF_PC, 32'h41);
        chk("redir_instr", IF_Instruction, 32'h140);

        // Two-cycle memory: valid every other cycle, address held two cycles.
        lat = 2;
        for (int a = 32'h42; a <= 32'h44; a++) push_exp(32'(a));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("lat2_valid", 32'(IF_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("lat2_addr", imem_addr, 32'(32'h41 + (i + 1) / 2));
        end

        // Redirect while stalled in HOLD flushes the skid.
        lat = 1;
        stall = 1'b1;
        step();
        chk("d_hold_req", 32'(imem_req), 32'd0);
        chk("d_hold_pc", IF_PC, 32'h45);
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        chk("d_flush_valid", 32'(IF_valid), 32'd0);
        chk("d_flush_req", 32'(imem_req), 32'd1);
        chk("d_flush_addr", imem_addr, 32'h80);
        chk("d_sb_left", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        redirect = 1'b0; stall = 1'b0;
        push_exp(32'h80);
        push_exp(32'h81);
        step();
        chk("d_new_pc", IF_PC, 32'h81);
        chk("d_new_instr", IF_Instruction, 32'h180);
        step();
        chk("d_next_pc", IF_PC, 32'h82);

        // Redirect in FETCH with ack in the same cycle.
        redirect = 1'b1; redirect_pc = 32'hC0;
        step();
        chk("e_valid", 32'(IF_valid), 32'd0);
        chk("e_addr", imem_addr, 32'hC0);
        chk("e_sb_left", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        redirect = 1'b0;
        push_exp(32'hC0);
        step();
        chk("e_pc", IF_PC, 32'hC1);
        chk("e_instr", IF_Instruction, 32'h1C0);
        chk("e_valid2", 32'(IF_valid), 32'd1);

        // Reset during a pending read.
        lat = 3;
        step();
        chk("f_sb_empty", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        chk("f_rst_pc", IF_PC, 32'd0);
        chk("f_rst_instr", IF_Instruction, 32'd0);
        chk("f_rst_valid", 32'(IF_valid), 32'd0);
        chk("f_rst_req", 32'(imem_req), 32'd0);
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("f_rst_ack_ignored", 32'(IF_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("f_release_addr", imem_addr, 32'd0);
        chk("f_release_req", 32'(imem_req), 32'd1);
        push_exp(32'd0);
        wait_valid(10);
        chk("f_first_pc", IF_PC, 32'd1);

        // Address wrap from RESET_PC = all ones (zero-wait memory).
        rst2 = 1'b0;
        #1;
        chk("w_first_addr", w_addr, 32'hFFFF_FFFF);
        chk("w_first_req", 32'(w_req), 32'd1);
        @(posedge clk);
        #1;
        chk("w_first_pc", w_pc, 32'd0);
        chk("w_first_instr", w_instr, 32'h0000_00FF);
        chk("w_second_addr", w_addr, 32'd0);
        @(posedge clk);
        #1;
        chk("w_second_pc", w_pc, 32'd1);
        rst2 = 1'b1;
        #1;
        chk("w_rst_pc", w_pc, 32'd0);
        chk("w_rst_instr", w_instr, 32'd0);
        chk("w_rst_valid", 32'(w_valid), 32'd0);
        chk("w_rst_req", 32'(w_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter ADDRESS_LEN, default 32, meaning PC/address width.
REQ-002 SHALL have parameter INSTRUCTION_LEN, default 32, meaning instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-004 SHALL have parameter PC_STEP, default 1, meaning PC increment per instruction (word addressing).
REQ-005 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port stall, input, 1, decode stage cannot accept a new instruction this cycle.
REQ-008 SHALL have port redirect, input, 1, branch/jump taken; flush and refetch.
REQ-009 SHALL have port redirect_pc, input, ADDRESS_LEN, target address for redirect.
REQ-010 SHALL have port imem_req, output, 1, instruction memory read request.
REQ-011 SHALL have port imem_addr, output, ADDRESS_LEN, read address.
REQ-012 SHALL have port imem_ack, input, 1, one-cycle pulse marking imem_rdata valid.
REQ-013 SHALL have port imem_rdata, input, INSTRUCTION_LEN, read data.
REQ-014 SHALL have port IF_PC, output, ADDRESS_LEN, fetched address + PC_STEP, feeds IF/ID PC input.
REQ-015 SHALL have port IF_Instruction, output, INSTRUCTION_LEN, fetched instruction, feeds IF/ID instruction input.
REQ-016 SHALL have port IF_valid, output, 1, IF_PC/IF_Instruction hold an unconsumed instruction.

Function
REQ-017 SHALL implement states FETCH (request active), HOLD (skid full, no request), DRAIN (discarding in-flight read after redirect).
REQ-018 SHALL assert imem_req in FETCH and DRAIN only; imem_addr SHALL remain stable from req assertion until the ack cycle; ack in the assertion cycle (zero wait) SHALL be accepted.
REQ-019 SHALL treat the output slot as free when IF_valid=0 or stall=0; an output with IF_valid=1 and stall=1 SHALL be held unchanged.
REQ-020 FETCH, ack, slot free: IF_Instruction<=imem_rdata, IF_PC<=pc+PC_STEP, IF_valid<=1, pc<=pc+PC_STEP, stay FETCH.
REQ-021 FETCH, ack, slot held: skid<=imem_rdata and pc+PC_STEP, pc<=pc+PC_STEP, go HOLD; no data lost.
REQ-022 FETCH, no ack, IF_valid=1, stall=0: IF_valid<=0 (consumed, bubble); IF_PC/IF_Instruction retain values.
REQ-023 HOLD, stall=0: outputs<=skid, IF_valid<=1, go FETCH; stall=1: remain HOLD, all outputs unchanged.
REQ-024 redirect SHALL take priority over stall and ack in every state: pc<=redirect_pc, IF_valid<=0, skid discarded.
REQ-025 redirect in FETCH with ack same cycle: data discarded, stay FETCH; next request addresses redirect_pc.
REQ-026 redirect in FETCH without ack: go DRAIN, keep old imem_addr; redirect in HOLD: go FETCH.
REQ-027 DRAIN: IF_valid stays 0; on ack discard data, go FETCH at pc; a further redirect in DRAIN SHALL update pc and stay DRAIN.
REQ-028 pc and IF_PC arithmetic SHALL be modulo 2^ADDRESS_LEN (wrap from max to 0 silently).
REQ-029 At most one outstanding memory read SHALL exist at any time.

Reset
REQ-030 rst SHALL immediately force pc=RESET_PC, IF_PC=0, IF_Instruction=0, IF_valid=0, skid empty, state FETCH.
REQ-031 imem_req SHALL be 0 while rst=1 and 1 with imem_addr=RESET_PC in the first cycle after release.
REQ-032 rst mid-transaction SHALL abandon the in-flight read; an ack arriving during rst SHALL be ignored.

Verification
REQ-033 Zero-wait memory (ack=req), stall=0, rdata=addr+0x100: IF_valid=1 every cycle from cycle 2, IF_PC=1,2,3..., IF_Instruction=0x100,0x101,...
REQ-034 2-cycle latency memory: imem_addr held 2 cycles per read; IF_valid pulses 1 every other cycle; no instruction skipped or duplicated.
REQ-035 Zero-wait, stall=1 for 3 cycles after instr at addr 4 is output: IF_Instruction for addr 4 held, state HOLD with addr 5 in skid, imem_req=0; stall release -> addr 5 output next cycle, then 6.
REQ-036 redirect=1, redirect_pc=0x40 while a 3-cycle read of addr 7 is pending: IF_valid=0, imem_addr=7 until ack, data discarded, next request addr 0x40, IF_PC=0x41.
REQ-037 redirect with stall=1 in HOLD: skid flushed, IF_valid=0, next fetch at redirect_pc.
REQ-038 RESET_PC=0xFFFFFFFF, zero-wait: first IF_PC=0, second fetch address 0; assert rst mid-read -> all outputs 0 immediately.
